// File: rtl/npc_mem_pkg.sv
// Shared types for the NPC memory-port arbiter.
package npc_mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_arb_state_t;

  // Requester identity; also records who owns the in-flight transaction.
  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } mem_owner_t;

endpackage : npc_mem_pkg

// File: rtl/mem_arbiter.sv
// Shares the single NPC memory port between the ICache refill path and the LSU.
// One single-beat transaction in flight; 2-way round-robin on ties.
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  // ICache refill requester (read only)
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  // LSU requester
  input  logic              lsu_req_valid,
  input  logic              lsu_req_wen,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  // Downstream memory port
  output logic              mem_req_valid,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  // Status / perf
  output logic              busy,
  output logic [31:0]       conflict_cnt
);

  mem_arb_state_t    r_state;
  mem_arb_state_t    w_state_nxt;
  mem_owner_t        r_last_owner;   // also the owner of the in-flight transaction
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [31:0]       r_conflict_cnt;

  logic w_idle;
  logic w_both;
  logic w_grant_lsu;
  logic w_grant_ic;

  // Round-robin pick: LSU wins when alone or when the IFU was served last.
  assign w_idle      = (r_state == IDLE);
  assign w_both      = ic_req_valid & lsu_req_valid;
  assign w_grant_lsu = lsu_req_valid & (~ic_req_valid | (r_last_owner == OWNER_IFU));
  assign w_grant_ic  = ic_req_valid & ~w_grant_lsu;

  // Downstream fields come only from the latched registers so they hold during stalls.
  assign mem_req_wen   = r_wen;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign busy          = ~w_idle;
  assign conflict_cnt  = r_conflict_cnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake/response outputs; readies are masked while reset is high.
  always_comb begin
    w_state_nxt    = r_state;
    ic_req_ready   = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ic_resp_valid  = 1'b0;
    ic_resp_data   = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    case (r_state)
      IDLE: begin
        ic_req_ready  = w_grant_ic & ~reset;
        lsu_req_ready = w_grant_lsu & ~reset;
        if (w_grant_ic | w_grant_lsu) w_state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = RESP;
      end
      RESP: begin
        if (r_last_owner == OWNER_IFU) begin
          ic_resp_valid = mem_resp_valid;
          ic_resp_data  = mem_resp_data;
        end else begin
          lsu_resp_valid = mem_resp_valid;
          lsu_resp_data  = mem_resp_data;
        end
        if (mem_resp_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the granted request; ICache requests are always reads with an empty mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_owner <= OWNER_IFU;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else if (w_idle) begin
      if (w_grant_lsu) begin
        r_last_owner <= OWNER_LSU;
        r_wen        <= lsu_req_wen;
        r_addr       <= lsu_req_addr;
        r_wdata      <= lsu_req_wdata;
        r_wmask      <= lsu_req_wmask;
      end else if (w_grant_ic) begin
        r_last_owner <= OWNER_IFU;
        r_wen        <= 1'b0;
        r_addr       <= ic_req_addr;
        r_wdata      <= '0;
        r_wmask      <= '0;
      end
    end
  end

  // Contention counter: IDLE cycles with both requesters valid, wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_conflict_cnt <= 32'd0;
    else if (w_idle & w_both) r_conflict_cnt <= r_conflict_cnt + 32'd1;
  end

endmodule : mem_arbiter
